// File: rtl/env_state_ram.sv
// Envelope/voice state RAM: one D_WIDTH word per {voice, env} pair, with a zero-fill
// sweep after reset, a per-voice clear sequencer and write-to-read forwarding.
module env_state_ram #(
  parameter int VOICES  = 8,
  parameter int V_ENVS  = 8,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3,
  parameter int D_WIDTH = 128
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       reset_reg_N,
  input  logic                       we,
  input  logic [V_WIDTH+E_WIDTH-1:0] write_address,
  input  logic [D_WIDTH-1:0]         d,
  input  logic [V_WIDTH+E_WIDTH-1:0] read_address,
  output logic [D_WIDTH-1:0]         q,
  input  logic                       clr_req,
  input  logic [V_WIDTH-1:0]         clr_voice,
  output logic                       busy
);

  localparam int A_WIDTH = V_WIDTH + E_WIDTH;
  localparam int DEPTH   = 1 << A_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_VCLR = 2'd2
  } state_t;

  state_t               state_q;
  logic [V_WIDTH-1:0]   voice_q;
  logic [E_WIDTH-1:0]   env_q;
  logic                 drain_q;
  logic                 busy_q;

  logic                 wen_q;
  logic [A_WIDTH-1:0]   waddr_q;
  logic [D_WIDTH-1:0]   wdata_q;
  logic [A_WIDTH-1:0]   raddr_q;
  logic [D_WIDTH-1:0]   q_q;

  logic [D_WIDTH-1:0]   mem_q [DEPTH];

  logic                 seq_issue;
  logic                 seq_last;
  logic                 last_env;
  logic                 last_voice;
  logic                 user_ok;
  logic                 clr_ok;
  logic [A_WIDTH-1:0]   seq_addr;

  // Holes in the address map (voice >= VOICES or env >= V_ENVS) are not backed by storage.
  function automatic logic addr_exists(input logic [A_WIDTH-1:0] a);
    return (int'(a[A_WIDTH-1:E_WIDTH]) < VOICES) && (int'(a[E_WIDTH-1:0]) < V_ENVS);
  endfunction

  always_comb begin
    seq_issue  = (state_q != ST_RUN) && !drain_q;
    seq_addr   = {voice_q, env_q};
    last_env   = (env_q == E_WIDTH'(V_ENVS - 1));
    last_voice = (voice_q == V_WIDTH'(VOICES - 1));
    seq_last   = last_env && ((state_q == ST_VCLR) || last_voice);
    user_ok    = (state_q == ST_RUN) && we && addr_exists(write_address);
    clr_ok     = (state_q == ST_RUN) && clr_req && (int'(clr_voice) < VOICES);
  end

  // Sequencer: issues one zero-write per cycle, then waits one drain cycle for the
  // last commit so busy falls only once the memory is really cleared.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      state_q <= ST_INIT;
      voice_q <= '0;
      env_q   <= '0;
      drain_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT, ST_VCLR: begin
          if (drain_q) begin
            state_q <= ST_RUN;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            if (seq_last) begin
              drain_q <= 1'b1;
            end
            if (last_env) begin
              env_q <= '0;
              if (state_q == ST_INIT) begin
                voice_q <= voice_q + V_WIDTH'(1);
              end
            end else begin
              env_q <= env_q + E_WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (clr_ok) begin
            state_q <= ST_VCLR;
            voice_q <= clr_voice;
            env_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_INIT;
          voice_q <= '0;
          env_q   <= '0;
          drain_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Write stage: address, data and enable are captured together and commit next edge.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (seq_issue) begin
      wen_q   <= 1'b1;
      waddr_q <= seq_addr;
      wdata_q <= '0;
    end else if (user_ok) begin
      wen_q   <= 1'b1;
      waddr_q <= write_address;
      wdata_q <= d;
    end else begin
      wen_q   <= 1'b0;
    end
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg_N && wen_q) begin
      mem_q[waddr_q] <= wdata_q;
    end
  end

  // Read stage; a commit landing on the same edge as the q load is forwarded.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      raddr_q <= '0;
      q_q     <= '0;
    end else begin
      raddr_q <= read_address;
      if (wen_q && (waddr_q == raddr_q)) begin
        q_q <= wdata_q;
      end else if (addr_exists(raddr_q)) begin
        q_q <= mem_q[raddr_q];
      end else begin
        q_q <= '0;
      end
    end
  end

  assign q    = q_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_env_state_ram.sv
// Bench for env_state_ram: a full-size and a six-voice instance share stimulus and are
// each checked every cycle against a transaction-level memory/busy model.
module tb_env_state_ram;

  logic         clk;
  logic         rst_n;
  logic         we;
  logic [5:0]   wa;
  logic [127:0] dd;
  logic [5:0]   ra;
  logic         clr;
  logic [2:0]   cv;
  logic [127:0] q0, q1;
  logic         busy0, busy1;

  env_state_ram #(.VOICES(8)) dut0 (
    .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .we(we), .write_address(wa), .d(dd),
    .read_address(ra), .q(q0), .clr_req(clr), .clr_voice(cv), .busy(busy0)
  );

  env_state_ram #(.VOICES(6)) dut1 (
    .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .we(we), .write_address(wa), .d(dd),
    .read_address(ra), .q(q1), .clr_req(clr), .clr_voice(cv), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] DB = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  int           tests = 0;
  int           fails = 0;
  int           nstep = 0;
  int           NV [2] = '{8, 6};
  logic [127:0] mm [2][64];
  bit           kn [2][64];
  int           busy_left [2];
  bit           init_act [2];
  int           init_idx [2];
  bit           clr_act [2];
  int           clr_v [2];
  int           clr_idx [2];
  logic [127:0] pend [2];
  bit           pend_v [2];

  typedef struct {
    bit           we;
    logic [5:0]   wa;
    logic [127:0] d;
    logic [5:0]   ra;
    bit           chk;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [12];

  function automatic bit exists(int i, logic [5:0] a);
    return int'(a[5:3]) < NV[i];
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, then advance the model and compare.
  task automatic step(input bit s_rst_n, input bit s_we, input logic [5:0] s_wa,
                      input logic [127:0] s_d, input logic [5:0] s_ra,
                      input bit s_clr, input logic [2:0] s_cv);
    rst_n = s_rst_n; we = s_we; wa = s_wa; dd = s_d; ra = s_ra; clr = s_clr; cv = s_cv;
    @(posedge clk);
    #1;
    nstep++;
    $display("[TB] step %0d rst_n=%0b we=%0b wa=%0o ra=%0o clr=%0b cv=%0d q0=%h busy0=%0b busy1=%0b",
             nstep, s_rst_n, s_we, s_wa, s_ra, s_clr, s_cv, q0, busy0, busy1);
    for (int i = 0; i < 2; i++) begin
      logic [127:0] qa;
      logic         ba;
      bit           run;
      int           a;
      qa = (i == 0) ? q0 : q1;
      ba = (i == 0) ? busy0 : busy1;
      if (!s_rst_n) begin
        busy_left[i] = NV[i] * 8 + 1;
        init_act[i]  = 1;
        init_idx[i]  = 0;
        clr_act[i]   = 0;
        for (int k = 0; k < 64; k++) kn[i][k] = 0;
        check($sformatf("rst_q%0d", i), qa, '0);
        check($sformatf("rst_busy%0d", i), {127'b0, ba}, 128'd1);
        pend_v[i] = 0;
      end else begin
        run = (busy_left[i] == 0);
        if (!run) busy_left[i]--;
        if (init_act[i]) begin
          mm[i][init_idx[i]] = '0;
          kn[i][init_idx[i]] = 1;
          init_idx[i]++;
          if (init_idx[i] == NV[i] * 8) init_act[i] = 0;
        end
        if (clr_act[i]) begin
          a = clr_v[i] * 8 + clr_idx[i];
          mm[i][a] = '0;
          kn[i][a] = 1;
          clr_idx[i]++;
          if (clr_idx[i] == 8) clr_act[i] = 0;
        end
        if (run && s_we && exists(i, s_wa)) begin
          mm[i][s_wa] = s_d;
          kn[i][s_wa] = 1;
        end
        if (run && s_clr && (int'(s_cv) < NV[i])) begin
          clr_act[i]   = 1;
          clr_v[i]     = int'(s_cv);
          clr_idx[i]   = 0;
          busy_left[i] = 9;
        end
        check($sformatf("busy%0d", i), {127'b0, ba}, {127'b0, busy_left[i] > 0});
        if (pend_v[i]) check($sformatf("q%0d", i), qa, pend[i]);
        if (!exists(i, s_ra)) begin
          pend[i]   = '0;
          pend_v[i] = 1;
        end else begin
          pend[i]   = mm[i][s_ra];
          pend_v[i] = kn[i][s_ra];
        end
      end
    end
  endtask

  task automatic idle(input logic [5:0] r);
    step(1, 0, 6'o0, '0, r, 0, 3'd0);
  endtask

  task automatic reset_and_init(input string tag);
    step(0, 0, 6'o0, '0, 6'o0, 0, 3'd0);
    for (int k = 1; k <= 65; k++) begin
      idle(6'o0);
      if (k == 48) check({tag, "_busy1_hi"}, {127'b0, busy1}, 128'd1);
      if (k == 49) check({tag, "_busy1_lo"}, {127'b0, busy1}, 128'd0);
      if (k == 64) check({tag, "_busy0_hi"}, {127'b0, busy0}, 128'd1);
      if (k == 65) check({tag, "_busy0_lo"}, {127'b0, busy0}, 128'd0);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) idle(6'(a));
    idle(6'o0);
  endtask

  initial begin
    int           nb;
    logic [5:0]   addr;
    logic [127:0] f;

    tbl[0]  = '{1, 6'o53, DB,       6'o00, 0, '0};
    tbl[1]  = '{0, 6'o00, '0,       6'o00, 1, '0};
    tbl[2]  = '{0, 6'o00, '0,       6'o53, 1, '0};
    tbl[3]  = '{0, 6'o00, '0,       6'o00, 1, DB};
    tbl[4]  = '{1, 6'o12, 128'd5,   6'o12, 1, '0};
    tbl[5]  = '{0, 6'o00, '0,       6'o13, 1, 128'd5};
    tbl[6]  = '{1, 6'o13, 128'd7,   6'o12, 1, '0};
    tbl[7]  = '{0, 6'o00, '0,       6'o13, 1, 128'd5};
    tbl[8]  = '{0, 6'o00, '0,       6'o13, 1, 128'd7};
    tbl[9]  = '{1, 6'o12, 128'd9,   6'o13, 1, 128'd7};
    tbl[10] = '{0, 6'o00, '0,       6'o12, 1, 128'd7};
    tbl[11] = '{0, 6'o00, '0,       6'o00, 1, 128'd9};

    rst_n = 0; we = 0; wa = '0; dd = '0; ra = '0; clr = 0; cv = '0;
    step(0, 0, 6'o0, '0, 6'o0, 0, 3'd0);
    reset_and_init("init");
    read_all();

    for (int r = 0; r < 12; r++) begin
      step(1, tbl[r].we, tbl[r].wa, tbl[r].d, tbl[r].ra, 0, 3'd0);
      if (tbl[r].chk) begin
        check($sformatf("tbl%0d_q0", r), q0, tbl[r].exp);
        check($sformatf("tbl%0d_q1", r), q1, tbl[r].exp);
      end
    end

    // Back-to-back read-modify-write through the forwarding path.
    foreach (NV[j]) begin end
    for (int r = 0; r < 4; r++) begin
      addr = 6'(7 + r * 11);
      idle(addr);
      idle(6'o0);
      f = mm[0][addr] + 128'd3;
      step(1, 1, addr, f, addr, 0, 3'd0);
      idle(6'o0);
      check($sformatf("rmw%0d_q0", r), q0, f);
      check($sformatf("rmw%0d_q1", r), q1, f);
    end

    // Fill everything, clear voice 3, and try a write while the clear is running.
    for (int a = 0; a < 64; a++) step(1, 1, 6'(a), {32'hA5A5_0000 + 32'(a), 96'h1}, 6'o0, 0, 3'd0);
    idle(6'o0);
    step(1, 0, 6'o0, '0, 6'o0, 1, 3'd3);
    nb = int'(busy0);
    for (int k = 1; k <= 11; k++) begin
      step(1, (k == 3), 6'o05, 128'hABC, 6'(24 + (k % 8)), 0, 3'd0);
      nb += int'(busy0);
    end
    check("vclr_busy_cycles", 128'(nb), 128'd9);
    read_all();
    idle(6'o05);
    idle(6'o0);
    check("drop_during_busy", q0, {32'hA5A5_0005, 96'h1});

    // Voice 6 exists only in the full-size instance; voice 7 writes are holes for dut1.
    step(1, 0, 6'o0, '0, 6'o0, 1, 3'd6);
    check("clr6_busy1_low", {127'b0, busy1}, 128'd0);
    check("clr6_busy0_high", {127'b0, busy0}, 128'd1);
    for (int k = 0; k < 10; k++) idle(6'o0);
    step(1, 1, 6'o73, 128'h1234, 6'o0, 0, 3'd0);
    idle(6'o73);
    idle(6'o0);
    check("hole_read_q1", q1, '0);
    check("voice7_q0", q0, 128'h1234);

    // Reset in the middle of a voice clear restarts the sweep.
    step(1, 0, 6'o0, '0, 6'o0, 1, 3'd2);
    idle(6'o0);
    idle(6'o0);
    idle(6'o0);
    reset_and_init("rinit");
    read_all();

    // Randomized traffic, including occasional clears and hole addresses.
    for (int k = 0; k < 600; k++) begin
      logic [5:0] rw;
      rw = 6'($urandom_range(0, 63));
      step(1, 1'($urandom_range(0, 1)), rw, {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 1) == 1) ? rw : 6'($urandom_range(0, 63)),
           ($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)));
    end
    for (int k = 0; k < 12; k++) idle(6'o0);
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
